// File: rtl/conv_result_collector.sv
// Collects one OUT_DIM x OUT_DIM convolution result frame into a local buffer,
// then streams it out in capture order over a valid/ready interface.
module conv_result_collector #(
   parameter int DATA_WIDTH  = 16,
   parameter int IMAGE_SIZE  = 28,
   parameter int KERNEL_SIZE = 5
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  enable,
   input  logic [DATA_WIDTH-1:0] conv_data,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  out_last,
   output logic                  frame_done,
   output logic                  busy,
   output logic                  overrun
);

   localparam int OUT_DIM = IMAGE_SIZE - KERNEL_SIZE + 1;
   localparam int FRAME   = OUT_DIM * OUT_DIM;
   localparam int PTR_W   = (FRAME > 1) ? $clog2(FRAME) : 1;
   localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(FRAME - 1);

   typedef enum logic [1:0] {
      IDLE,
      COLLECT,
      DRAIN
   } state_e;

   state_e                  state_q, state_d;
   logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
   logic                    frame_done_q, frame_done_d;
   logic                    overrun_q, overrun_d;
   logic                    capture;
   logic [DATA_WIDTH-1:0]   buf_q [FRAME];

   // Next-state, pointer and output decode for the collect/drain sequence.
   always_comb begin
      state_d      = state_q;
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      frame_done_d = 1'b0;
      overrun_d    = overrun_q;
      capture      = 1'b0;

      unique case (state_q)
         IDLE, COLLECT: begin
            if (enable) begin
               capture = 1'b1;
               if (wr_ptr_q == LAST_IDX) begin
                  wr_ptr_d     = '0;
                  rd_ptr_d     = '0;
                  frame_done_d = 1'b1;
                  state_d      = DRAIN;
               end else begin
                  wr_ptr_d = wr_ptr_q + PTR_W'(1);
                  state_d  = COLLECT;
               end
            end
         end
         DRAIN: begin
            // Results arriving while draining (including the final transfer
            // cycle) are discarded and flagged.
            if (enable) overrun_d = 1'b1;
            if (out_ready) begin
               if (rd_ptr_q == LAST_IDX) begin
                  rd_ptr_d = '0;
                  state_d  = IDLE;
               end else begin
                  rd_ptr_d = rd_ptr_q + PTR_W'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase

      out_valid  = (state_q == DRAIN);
      out_last   = (state_q == DRAIN) && (rd_ptr_q == LAST_IDX);
      out_data   = (state_q == DRAIN) ? buf_q[rd_ptr_q] : '0;
      busy       = (state_q != IDLE);
      frame_done = frame_done_q;
      overrun    = overrun_q;
   end

   // Control state register with asynchronous active-low reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= IDLE;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         frame_done_q <= 1'b0;
         overrun_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         frame_done_q <= frame_done_d;
         overrun_q    <= overrun_d;
      end
   end

   // Frame buffer write; contents deliberately survive reset.
   always_ff @(posedge clk) begin
      if (capture) buf_q[wr_ptr_q] <= conv_data;
   end

endmodule

// File: tb/tb_conv_result_collector.sv
// Directed bench for conv_result_collector: a queue-based frame model checked
// every cycle, plus literal expectations on the emitted streams.
module tb_conv_result_collector;

   localparam int FRAME   = 576;
   localparam int S_FRAME = 36;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        enable = 1'b0;
   logic [15:0] conv_data = '0;
   logic        out_ready = 1'b1;
   logic [15:0] out_data;
   logic        out_valid, out_last, frame_done, busy, overrun;

   logic        s_en = 1'b0;
   logic [15:0] s_data = '0;
   logic        s_rdy = 1'b1;
   logic [15:0] s_out_data;
   logic        s_valid, s_last, s_fd, s_busy, s_ovr;

   int vectors = 0;
   int miscompares = 0;

   conv_result_collector dut (
      .clk(clk), .reset(reset), .enable(enable), .conv_data(conv_data),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_last(out_last), .frame_done(frame_done), .busy(busy), .overrun(overrun)
   );

   conv_result_collector #(.DATA_WIDTH(16), .IMAGE_SIZE(8), .KERNEL_SIZE(3)) dut_s (
      .clk(clk), .reset(reset), .enable(s_en), .conv_data(s_data),
      .out_data(s_out_data), .out_valid(s_valid), .out_ready(s_rdy),
      .out_last(s_last), .frame_done(s_fd), .busy(s_busy), .overrun(s_ovr)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Behavioural model: words captured so far in this frame, and words still to emit.
   logic [15:0] capt[$];
   logic [15:0] outq[$];
   logic        m_fd = 1'b0;
   logic        m_ovr = 1'b0;

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         capt.delete();
         outq.delete();
         m_fd  = 1'b0;
         m_ovr = 1'b0;
      end else begin
         m_fd = 1'b0;
         if (outq.size() > 0) begin
            if (enable) m_ovr = 1'b1;
            if (out_ready) void'(outq.pop_front());
         end else if (enable) begin
            capt.push_back(conv_data);
            if (capt.size() == FRAME) begin
               outq = capt;
               capt.delete();
               m_fd = 1'b1;
            end
         end
      end
   end

   // Emitted streams and frame_done pulses, recorded for literal checks.
   logic [15:0] em[$];
   logic        em_last[$];
   logic [15:0] s_em[$];
   logic        s_em_last[$];
   int          fd_cnt = 0;

   // Per-cycle comparison against the model, sampled mid-cycle.
   always @(negedge clk) begin
      chk("out_valid", 32'(out_valid), (outq.size() > 0) ? 32'd1 : 32'd0);
      chk("out_data", 32'(out_data), (outq.size() > 0) ? 32'(outq[0]) : 32'd0);
      chk("out_last", 32'(out_last), (outq.size() == 1) ? 32'd1 : 32'd0);
      chk("frame_done", 32'(frame_done), 32'(m_fd));
      chk("busy", 32'(busy), (outq.size() > 0 || capt.size() > 0) ? 32'd1 : 32'd0);
      chk("overrun", 32'(overrun), 32'(m_ovr));
      if (reset) begin
         if (frame_done) fd_cnt++;
         if (out_valid && out_ready) begin
            em.push_back(out_data);
            em_last.push_back(out_last);
         end
         if (s_valid && s_rdy) begin
            s_em.push_back(s_out_data);
            s_em_last.push_back(s_last);
         end
      end
   end

   task automatic cyc(input logic en, input logic [15:0] d, input logic rdy);
      enable    = en;
      conv_data = d;
      out_ready = rdy;
      @(posedge clk);
      #1;
   endtask

   task automatic capture(input int n, input int base, input bit gap);
      for (int i = 0; i < n; i++) begin
         cyc(1'b1, 16'(base + i), 1'b1);
         if (gap) cyc(1'b0, 16'hFFFF, 1'b1);
      end
   endtask

   // Drain until idle; enable is raised on drain cycles en_lo..en_hi.
   task automatic drain(input int pct, input int en_lo, input int en_hi);
      int n;
      n = 0;
      while (busy && n < 20000) begin
         cyc((n >= en_lo && n <= en_hi) ? 1'b1 : 1'b0, 16'hBEEF,
             ($urandom_range(0, 99) < pct) ? 1'b1 : 1'b0);
         n++;
      end
      enable = 1'b0;
      chk("drain_done", 32'(busy), 32'd0);
   endtask

   task automatic check_stream(input string nm, input int base);
      chk({nm, "_count"}, 32'(em.size()), 32'(FRAME));
      for (int i = 0; i < FRAME && i < em.size(); i++) begin
         chk({nm, "_word"}, 32'(em[i]), 32'(base + i));
         chk({nm, "_last"}, 32'(em_last[i]), (i == FRAME - 1) ? 32'd1 : 32'd0);
      end
      em.delete();
      em_last.delete();
   endtask

   initial begin
      #2 reset = 1'b0;
      repeat (3) cyc(1'b0, 16'h0, 1'b1);
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_data", 32'(out_data), 32'd0);
      reset = 1'b1;
      cyc(1'b0, 16'h0, 1'b1);

      // Continuous frame.
      fd_cnt = 0;
      capture(FRAME, 0, 1'b0);
      drain(100, -1, -1);
      check_stream("cont", 0);
      chk("cont_fd_pulses", 32'(fd_cnt), 32'd1);

      // Gapped input: capture, gap, capture, gap ...
      fd_cnt = 0;
      capture(FRAME, 0, 1'b1);
      drain(100, -1, -1);
      check_stream("gap", 0);
      chk("gap_fd_pulses", 32'(fd_cnt), 32'd1);

      // Backpressure at 30% ready.
      capture(FRAME, 1000, 1'b0);
      drain(30, -1, -1);
      check_stream("bp", 1000);

      // Overrun during drain, then a normal second frame.
      capture(FRAME, 2000, 1'b0);
      drain(100, 10, 12);
      check_stream("ovr", 2000);
      chk("ovr_flag", 32'(overrun), 32'd1);
      capture(FRAME, 3000, 1'b0);
      drain(100, -1, -1);
      check_stream("ovr2", 3000);
      chk("ovr_sticky", 32'(overrun), 32'd1);

      // Reset after 100 captures abandons the partial frame.
      capture(100, 5000, 1'b0);
      reset = 1'b0;
      cyc(1'b0, 16'h0, 1'b1);
      chk("mid_rst_ovr", 32'(overrun), 32'd0);
      chk("mid_rst_fd", 32'(frame_done), 32'd0);
      reset = 1'b1;
      cyc(1'b0, 16'h0, 1'b1);
      em.delete();
      em_last.delete();
      // New frame; a capture on the final transfer cycle is dropped.
      capture(FRAME, 7000, 1'b0);
      drain(100, FRAME - 1, FRAME - 1);
      check_stream("after_rst", 7000);
      chk("last_cycle_ovr", 32'(overrun), 32'd1);
      chk("last_cycle_idle", 32'(busy), 32'd0);

      // Small instance: 8x8 image, 3x3 kernel -> 36-word frame.
      s_rdy = 1'b1;
      for (int i = 0; i < S_FRAME; i++) begin
         s_en   = 1'b1;
         s_data = 16'(i + 100);
         cyc(1'b0, 16'h0, 1'b1);
      end
      s_en = 1'b0;
      for (int i = 0; i < 100 && s_busy; i++) cyc(1'b0, 16'h0, 1'b1);
      chk("s_idle", 32'(s_busy), 32'd0);
      chk("s_count", 32'(s_em.size()), 32'd36);
      for (int i = 0; i < s_em.size(); i++) begin
         chk("s_word", 32'(s_em[i]), 32'(i + 100));
         chk("s_last", 32'(s_em_last[i]), (i == 35) ? 32'd1 : 32'd0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
